// File: rtl/alu_pkg.sv
// Shared opcode, shifter-select and flag-index definitions for the alu_core block.
package alu_pkg;

    typedef enum logic [3:0] {
        OP_ADD  = 4'b0000,
        OP_SUB  = 4'b0001,
        OP_AND  = 4'b0010,
        OP_OR   = 4'b0011,
        OP_XOR  = 4'b0100,
        OP_NOT  = 4'b0101,
        OP_SLL  = 4'b0110,
        OP_SRL  = 4'b0111,
        OP_SRA  = 4'b1000,
        OP_MUL  = 4'b1001,
        OP_SLT  = 4'b1010,
        OP_SLTU = 4'b1011,
        OP_MIN  = 4'b1100,
        OP_MAX  = 4'b1101,
        OP_PASS = 4'b1110,
        OP_RSVD = 4'b1111
    } alu_op_e;

    typedef enum logic [1:0] {
        SH_SLL = 2'b00,
        SH_SRL = 2'b01,
        SH_SRA = 2'b10
    } shift_op_e;

    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

endpackage

// File: rtl/alu_if.sv
// Operand/opcode/result bundle between the issue logic (master) and alu_core (slave).
interface alu_if #(
    parameter int N = 16
);
    logic signed [N-1:0] a;
    logic signed [N-1:0] b;
    logic        [3:0]   ctrl;
    logic signed [N-1:0] result;
    logic        [3:0]   flags;

    modport master (
        output a,
        output b,
        output ctrl,
        input  result,
        input  flags
    );

    modport slave (
        input  a,
        input  b,
        input  ctrl,
        output result,
        output flags
    );
endinterface

// File: rtl/alu_shifter.sv
// Combinational SLL/SRL/SRA; carry is the last bit shifted out (0 for a zero shift).
module alu_shifter
    import alu_pkg::*;
#(
    parameter int N = 16,
    localparam int SW = $clog2(N)
) (
    input  logic [N-1:0] a,
    input  logic [SW-1:0] shamt,
    input  shift_op_e    op,
    output logic [N-1:0] res,
    output logic         carry
);
    // One guard bit beside the operand catches the final bit that falls off;
    // it is zero when nothing moves, so a zero shift yields carry 0 for free.
    logic        [N:0] left_ext;
    logic        [N:0] right_ext;
    logic signed [N:0] arith_ext;

    always_comb begin
        left_ext  = {1'b0, a} << shamt;
        right_ext = {a, 1'b0} >> shamt;
        arith_ext = $signed({a, 1'b0}) >>> shamt;
        res       = '0;
        carry     = 1'b0;
        case (op)
            SH_SLL: begin
                res   = left_ext[N-1:0];
                carry = left_ext[N];
            end
            SH_SRL: begin
                res   = right_ext[N:1];
                carry = right_ext[0];
            end
            SH_SRA: begin
                res   = arith_ext[N:1];
                carry = arith_ext[0];
            end
            default: begin
                res   = '0;
                carry = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/alu_core.sv
// Registered N-bit integer ALU with NZCV flags and one-cycle latency.
// Optional signed multiplier is built only when ALU_MUL_EN is defined.
module alu_core
    import alu_pkg::*;
#(
    parameter int N = 16,
    localparam int SW = $clog2(N)
) (
    input  logic  clk,
    input  logic  rst_n,
    alu_if.slave  bus
);
    alu_op_e      op;
    logic [N-1:0] result_next;
    logic         carry_next;
    logic         ovf_next;
    logic [3:0]   flags_next;
    logic [N-1:0] result_reg;
    logic [3:0]   flags_reg;

    assign op = alu_op_e'(bus.ctrl);

    // Add and subtract share one adder: a - b is a + ~b + 1, borrow is ~carry.
    logic         is_sub;
    logic [N-1:0] b_eff;
    logic [N:0]   sum_full;
    logic         add_ovf;

    assign is_sub   = (op == OP_SUB);
    assign b_eff    = is_sub ? ~bus.b : bus.b;
    assign sum_full = {1'b0, bus.a} + {1'b0, b_eff} + {{N{1'b0}}, is_sub};
    assign add_ovf  = (bus.a[N-1] == b_eff[N-1]) && (sum_full[N-1] != bus.a[N-1]);

    shift_op_e    sh_op;
    logic [N-1:0] sh_res;
    logic         sh_carry;

    always_comb begin
        sh_op = SH_SLL;
        case (op)
            OP_SRL:  sh_op = SH_SRL;
            OP_SRA:  sh_op = SH_SRA;
            default: sh_op = SH_SLL;
        endcase
    end

    alu_shifter #(.N(N)) u_shifter (
        .a     (bus.a),
        .shamt (bus.b[SW-1:0]),
        .op    (sh_op),
        .res   (sh_res),
        .carry (sh_carry)
    );

    logic lt_signed;
    logic lt_unsigned;

    assign lt_signed   = ($signed(bus.a) < $signed(bus.b));
    assign lt_unsigned = ($unsigned(bus.a) < $unsigned(bus.b));

`ifdef ALU_MUL_EN
    // The product fits in N bits only when its upper N+1 bits are a pure sign extension.
    logic signed [2*N-1:0] product;
    logic                  mul_ovf;

    assign product = $signed(bus.a) * $signed(bus.b);
    assign mul_ovf = (product[2*N-1:N-1] != {(N+1){product[N-1]}});
`endif

    always_comb begin
        result_next = '0;
        carry_next  = 1'b0;
        ovf_next    = 1'b0;
        case (op)
            OP_ADD: begin
                result_next = sum_full[N-1:0];
                carry_next  = sum_full[N];
                ovf_next    = add_ovf;
            end
            OP_SUB: begin
                result_next = sum_full[N-1:0];
                carry_next  = ~sum_full[N];
                ovf_next    = add_ovf;
            end
            OP_AND:  result_next = bus.a & bus.b;
            OP_OR:   result_next = bus.a | bus.b;
            OP_XOR:  result_next = bus.a ^ bus.b;
            OP_NOT:  result_next = ~bus.a;
            OP_SLL, OP_SRL, OP_SRA: begin
                result_next = sh_res;
                carry_next  = sh_carry;
            end
`ifdef ALU_MUL_EN
            OP_MUL: begin
                result_next = product[N-1:0];
                ovf_next    = mul_ovf;
            end
`endif
            OP_SLT:  result_next = {{(N-1){1'b0}}, lt_signed};
            OP_SLTU: result_next = {{(N-1){1'b0}}, lt_unsigned};
            OP_MIN:  result_next = lt_signed ? bus.a : bus.b;
            OP_MAX:  result_next = lt_signed ? bus.b : bus.a;
            OP_PASS: result_next = bus.b;
            default: begin
                result_next = '0;
                carry_next  = 1'b0;
                ovf_next    = 1'b0;
            end
        endcase
    end

    always_comb begin
        flags_next         = '0;
        flags_next[FLAG_N] = result_next[N-1];
        flags_next[FLAG_Z] = (result_next == '0);
        flags_next[FLAG_C] = carry_next;
        flags_next[FLAG_V] = ovf_next;
    end

    // Reset clears flags too, so Z is deliberately 0 in the reset state.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            result_reg <= '0;
            flags_reg  <= '0;
        end else begin
            result_reg <= result_next;
            flags_reg  <= flags_next;
        end
    end

    assign bus.result = result_reg;
    assign bus.flags  = flags_reg;

endmodule

// File: tb/tb_alu_core.sv
// Self-checking bench for alu_core (N=16): directed vector table, hand-written
// reset/timing sequences, and back-to-back random operations against a reference model.
module tb_alu_core;

    localparam int N = 16;

    logic clk;
    logic rst_n;
    int   total_checks;
    int   passed_checks;

    alu_if #(.N(N)) bus ();

    alu_core #(.N(N)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [15:0] a;
        logic [15:0] b;
        logic [3:0]  ctrl;
        logic [15:0] exp_result;
        logic [3:0]  exp_flags;
    } vec_t;

    // Reference model from the arithmetic definitions, using wide signed/unsigned integers.
    function automatic logic [19:0] model(input logic [15:0] a, input logic [15:0] b,
                                          input logic [3:0] op);
        longint sa;
        longint sb;
        longint ua;
        longint ub;
        longint r;
        int     sh;
        bit     c;
        bit     v;
        logic [15:0] res;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = longint'(a);
        ub = longint'(b);
        sh = int'(b[3:0]);
        r  = 0;
        c  = 1'b0;
        v  = 1'b0;
        case (op)
            4'd0: begin r = sa + sb; c = (ua + ub) > 65535; v = (r > 32767) || (r < -32768); end
            4'd1: begin r = sa - sb; c = ua < ub;           v = (r > 32767) || (r < -32768); end
            4'd2: r = ua & ub;
            4'd3: r = ua | ub;
            4'd4: r = ua ^ ub;
            4'd5: r = ~ua;
            4'd6: begin r = ua << sh;  c = (sh != 0) && (((ua >> (16 - sh)) & 1) == 1); end
            4'd7: begin r = ua >> sh;  c = (sh != 0) && (((ua >> (sh - 1)) & 1) == 1); end
            4'd8: begin r = sa >>> sh; c = (sh != 0) && (((ua >> (sh - 1)) & 1) == 1); end
`ifdef ALU_MUL_EN
            4'd9: begin r = sa * sb; v = (r > 32767) || (r < -32768); end
`endif
            4'd10: r = (sa < sb) ? 1 : 0;
            4'd11: r = (ua < ub) ? 1 : 0;
            4'd12: r = (sa < sb) ? sa : sb;
            4'd13: r = (sa < sb) ? sb : sa;
            4'd14: r = ub;
            default: r = 0;
        endcase
        res = r[15:0];
        return {res, res[15], (res == 16'h0000), c, v};
    endfunction

    task automatic check(input string name, input logic [15:0] exp_r, input logic [3:0] exp_f);
        total_checks++;
        if (bus.result === exp_r && bus.flags === exp_f) begin
            passed_checks++;
            $display("ok   %s a=%h b=%h ctrl=%b result=%h flags=%b", name, bus.a, bus.b,
                     bus.ctrl, bus.result, bus.flags);
        end else begin
            $display("FAIL %s a=%h b=%h ctrl=%b got result=%h flags=%b expected result=%h flags=%b",
                     name, bus.a, bus.b, bus.ctrl, bus.result, bus.flags, exp_r, exp_f);
        end
    endtask

    function automatic logic [15:0] rand_operand();
        case ($urandom_range(0, 7))
            0:       return 16'h7FFF;
            1:       return 16'h8000;
            2:       return 16'hFFFF;
            3:       return 16'h0000;
            4:       return 16'($urandom_range(0, 20));
            default: return 16'($urandom);
        endcase
    endfunction

    vec_t vecs[];

    initial begin
        logic [19:0] exp_q[$];
        logic [19:0] e;
        logic [15:0] ra;
        logic [15:0] rb;
        logic [3:0]  rc;

        total_checks  = 0;
        passed_checks = 0;

        vecs = new[24];
        vecs[0]  = '{16'd4857,  16'd7465, 4'b0000, 16'd12322, 4'b0000};
        vecs[1]  = '{16'd7465,  16'd4857, 4'b0001, 16'd2608,  4'b0000};
        vecs[2]  = '{16'hFFFB,  16'd2,    4'b0000, 16'hFFFD,  4'b1000};
        vecs[3]  = '{16'hFFFB,  16'd2,    4'b0001, 16'hFFF9,  4'b1000};
        vecs[4]  = '{16'h7FFF,  16'd1,    4'b0000, 16'h8000,  4'b1001};
        vecs[5]  = '{16'hFFFF,  16'd1,    4'b0000, 16'h0000,  4'b0110};
        vecs[6]  = '{16'd2,     16'd5,    4'b0001, 16'hFFFD,  4'b1010};
        vecs[7]  = '{16'h8001,  16'd1,    4'b1000, 16'hC000,  4'b1010};
        vecs[8]  = '{16'h8001,  16'd1,    4'b0110, 16'h0002,  4'b0010};
        vecs[9]  = '{16'h8001,  16'd0,    4'b0111, 16'h8001,  4'b1000};
`ifdef ALU_MUL_EN
        vecs[10] = '{16'd300,   16'd300,  4'b1001, 16'h5F90,  4'b0001};
`else
        vecs[10] = '{16'd300,   16'd300,  4'b1001, 16'h0000,  4'b0100};
`endif
        vecs[11] = '{16'd5,     16'd5,    4'b1111, 16'h0000,  4'b0100};
        vecs[12] = '{16'hF0F0,  16'h0FF0, 4'b0010, 16'h00F0,  4'b0000};
        vecs[13] = '{16'hF0F0,  16'h0FF0, 4'b0011, 16'hFFF0,  4'b1000};
        vecs[14] = '{16'hF0F0,  16'h0FF0, 4'b0100, 16'hFF00,  4'b1000};
        vecs[15] = '{16'hF0F0,  16'h0FF0, 4'b0101, 16'h0F0F,  4'b0000};
        vecs[16] = '{16'hFFFF,  16'd1,    4'b1010, 16'h0001,  4'b0000};
        vecs[17] = '{16'hFFFF,  16'd1,    4'b1011, 16'h0000,  4'b0100};
        vecs[18] = '{16'hFFFD,  16'd2,    4'b1100, 16'hFFFD,  4'b1000};
        vecs[19] = '{16'hFFFD,  16'd2,    4'b1101, 16'h0002,  4'b0000};
        vecs[20] = '{16'h1234,  16'h0000, 4'b1110, 16'h0000,  4'b0100};
        vecs[21] = '{16'h8000,  16'd15,   4'b1000, 16'hFFFF,  4'b1000};
        vecs[22] = '{16'h0001,  16'd15,   4'b0110, 16'h8000,  4'b1000};
        vecs[23] = '{16'h8000,  16'h8000, 4'b0001, 16'h0000,  4'b0100};

        // Reset held across an edge with an ADD presented.
        rst_n    = 1'b0;
        bus.a    = 16'd5;
        bus.b    = 16'd5;
        bus.ctrl = 4'b0000;
        @(negedge clk);
        @(negedge clk);
        check("reset", 16'h0000, 4'b0000);

        rst_n = 1'b1;
        for (int i = 0; i < vecs.size(); i++) begin
            bus.a    = vecs[i].a;
            bus.b    = vecs[i].b;
            bus.ctrl = vecs[i].ctrl;
            @(negedge clk);
            check($sformatf("vec%0d", i), vecs[i].exp_result, vecs[i].exp_flags);
        end

        // Reset wins over a live operation, then the first result appears one edge after release.
        bus.a    = 16'd4857;
        bus.b    = 16'd7465;
        bus.ctrl = 4'b0000;
        @(negedge clk);
        check("pre_reset_add", 16'd12322, 4'b0000);
        rst_n = 1'b0;
        @(negedge clk);
        check("reset_priority", 16'h0000, 4'b0000);
        rst_n = 1'b1;
        @(negedge clk);
        check("first_after_release", 16'd12322, 4'b0000);

        // Inputs changed between edges must not disturb the registered outputs.
        bus.a    = 16'd1;
        bus.b    = 16'd2;
        bus.ctrl = 4'b0000;
        @(posedge clk);
        #1;
        check("latency_one_edge", 16'd3, 4'b0000);
        #1;
        bus.b    = 16'h1234;
        bus.ctrl = 4'b1110;
        @(negedge clk);
        check("hold_between_edges", 16'd3, 4'b0000);
        @(negedge clk);
        check("next_edge_pass", 16'h1234, 4'b0000);

        // Back-to-back random operations, one per cycle.
        for (int i = 0; i < 300; i++) begin
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                check($sformatf("rand%0d", i - 1), e[19:4], e[3:0]);
            end
            ra = rand_operand();
            rb = rand_operand();
            rc = 4'($urandom_range(0, 15));
            bus.a    = ra;
            bus.b    = rb;
            bus.ctrl = rc;
            exp_q.push_back(model(ra, rb, rc));
            @(negedge clk);
        end
        e = exp_q.pop_front();
        check("rand_last", e[19:4], e[3:0]);

        $display("%0d/%0d checks passed", passed_checks, total_checks);
        $finish;
    end

endmodule

// File: doc/alu_core.md
# alu_core

16-bit-default registered integer ALU for the execute stage of the Tessia vector/scalar pipeline. It takes two signed operands and a 4-bit operation code and computes one of 15 arithmetic, logic, shift or compare results. It registers the result and a 4-bit NZCV flag vector on the rising clock edge, and the flags feed branch/condition logic downstream.

## Interface
- `N`, default 16: operand/result width in bits; legal range is 4 to 64.
- `clk` input, 1 bit: single clock. All state updates on its rising edge.
- `rst_n` input, 1 bit: reset, synchronous and active-low.
- `a` input, N bits, signed: operand A.
- `b` input, N bits, signed: operand B. Its low `$clog2(N)` bits are the shift amount.
- `ctrl` input, 4 bits: operation select.
- `result` output, N bits, signed: registered result.
- `flags` output, 4 bits: registered flags `{N, Z, C, V}`. Bit 3 is Negative, bit 2 is Zero, bit 1 is Carry/borrow, bit 0 is signed overflow.

## Operation
Opcodes for `ctrl`:
- 0000 ADD: a+b. C = carry out of the MSB. V = signed overflow.
- 0001 SUB: a−b. C = borrow, i.e. a<b unsigned. V = signed overflow.
- 0010 AND, 0011 OR, 0100 XOR: bitwise. C=0, V=0.
- 0101 NOT: ~a. C=0, V=0.
- 0110 SLL, 0111 SRL, 1000 SRA: shift a by `b[$clog2(N)-1:0]`. C = last bit shifted out, and C=0 when the shift amount is 0. V=0.
- 1001 MUL: low N bits of the signed product a×b. C=0. V=1 if the full signed product does not fit in N bits.
- 1010 SLT: result 1 if a<b signed, else 0. 1011 SLTU: result 1 if a<b unsigned, else 0. C=0, V=0.
- 1100 MIN, 1101 MAX: signed minimum/maximum of a and b. C=0, V=0.
- 1110 PASS: result = b. C=0, V=0.
- 1111 reserved: result 0. C=0, V=0.

Flag rules for every opcode:
- N = result[N−1].
- Z = (result == 0).

Arithmetic rules:
- All arithmetic is two's complement and wraps modulo 2^N.

## Timing
- Latency: exactly one cycle. Outputs reflect the `a`, `b`, `ctrl` values sampled at the previous rising edge.
- Throughput: one operation per cycle. There is no handshake or stall.
- Reset: on a rising edge with `rst_n`=0, `result` becomes 0 and `flags` becomes 4'b0000. Z is not set in the reset state.
- Reset takes priority over any operation sampled in the same cycle.
- The first valid result appears one edge after `rst_n` is released.
- Inputs that change between edges have no effect on the outputs until the next edge.

## Configuration
- Macro: `ALU_MUL_EN`.
- With `ALU_MUL_EN` defined: opcode 1001 performs MUL as specified above.
- Without `ALU_MUL_EN`: no multiplier is synthesized. Opcode 1001 behaves exactly like reserved: result 0 and flags 0100.

## Structure
- Package `alu_pkg` holds:
  - the `alu_op_e` enum of the 4-bit opcodes;
  - the flag bit index constants `FLAG_N`=3, `FLAG_Z`=2, `FLAG_C`=1, `FLAG_V`=0.
- Sub-module `alu_shifter` (combinational): SLL/SRL/SRA with shifted-out-bit carry.
- The top-level `alu_core` contains:
  - the combinational operation mux;
  - add/sub, with subtraction done as a + ~b + 1 and borrow = ~carry;
  - the optional multiplier;
  - the output registers.

## Test plan
All scenarios use N=16. Results are checked one edge after stimulus.
- Reset: hold `rst_n`=0 across an edge with a=5, b=5, ctrl=0000. Required: result=0, flags=0000.
- ADD/SUB positive:
  - a=4857, b=7465, ADD → result 12322, flags 0000.
  - a=7465, b=4857, SUB → result 2608, flags 0000.
- Negative results:
  - a=−5, b=2, ADD → result −3, flags 1000.
  - a=−5, b=2, SUB → result −7, flags 1000.
- Overflow/carry/zero:
  - 32767+1 → result −32768, flags 1001.
  - −1+1 → result 0, flags 0110.
  - 2−5 → result −3, flags 1010.
- Shifts:
  - a=16'h8001, b=1, SRA → result 16'hC000, flags 1010.
  - SLL by 1 → result 16'h0002, flags 0010.
  - SRL with b=0 → result unchanged, C=0.
- MUL and reserved:
  - 300×300 → result 16'h5F90, V=1 with `ALU_MUL_EN`.
  - Without `ALU_MUL_EN`, the same MUL stimulus → result 0, flags 0100.
  - ctrl=1111 → result 0, flags 0100.
